auth_rx: RTL and testbench
==========================

AUTH_RX -- requirements
Module: auth_rx

Interface
REQ-001 Parameter BAUD_CNT, default 2604, clocks per UART bit (50 MHz / 19200 baud); legal range 8..4095.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 RX  input  1  asynchronous UART serial line from the BLE module; 8N1, idle high.
REQ-005 rider_off  input  1  high when the load cells report no rider; synchronous to clk.
REQ-006 rx_data  output  8  last correctly framed byte received.
REQ-007 rx_rdy  output  1  one-cycle pulse when rx_data has been updated.
REQ-008 frm_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 pwr_up  output  1  registered power-enable to the balance controller.

Function
REQ-010 RX passes through a two-flop synchronizer, preset high, before any use; synchronizer latency is 2 cycles.
REQ-011 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HI.
REQ-012 IDLE: on a synchronized falling edge (previous 1, current 0), load the baud counter with BAUD_CNT/2 (truncating) and enter START.
REQ-013 Baud counter: decrements each cycle; it is 12 bits wide and saturates at 0; a sample is taken in the cycle it reaches 0, after which it reloads with BAUD_CNT.
REQ-014 START sample = 1 -> false start: return to IDLE with no pulse; sample = 0 -> enter DATA.
REQ-015 DATA: shift 8 samples LSB first into the shift register; a 4-bit bit counter tracks the bits; after the 8th sample enter STOP.
REQ-016 STOP sample = 1 -> rx_data <= shift register and rx_rdy = 1 for exactly one cycle, then IDLE.
REQ-017 STOP sample = 0 -> frm_err = 1 for one cycle, rx_data unchanged, no rx_rdy, then WAIT_HI.
REQ-018 WAIT_HI: remain until synchronized RX = 1, then IDLE; this prevents a break condition from retriggering.
REQ-019 rx_rdy and frm_err are mutually exclusive and are never asserted on consecutive cycles.
REQ-020 Auth FSM states: OFF, PWR1 (running), PWR2 (stop requested, rider still on).
REQ-021 OFF: rx_rdy with rx_data = 0x47 ('G') -> PWR1; all other bytes ignored.
REQ-022 PWR1: rx_rdy with 0x53 ('S') -> OFF if rider_off = 1, else PWR2; other bytes ignored.
REQ-023 PWR2: rider_off = 1 -> OFF; rx_rdy with 0x47 -> PWR1; if both occur in the same cycle, the 'G' wins -> PWR1.
REQ-024 pwr_up = 1 in PWR1 and PWR2 and 0 in OFF; it is a flop output and changes in the cycle after the qualifying rx_rdy or rider_off.
REQ-025 rider_off has no effect in OFF or PWR1; only an 'S' arms shutdown.
REQ-026 frm_err never changes auth state.

Reset
REQ-027 When rst = 1 at a clk edge: receiver -> IDLE, auth FSM -> OFF, synchronizer flops -> 1, counters -> 0, and shift register -> 0.
REQ-028 Outputs after reset: rx_data = 0x00, rx_rdy = 0, frm_err = 0, pwr_up = 0.
REQ-029 Reset asserted mid-frame aborts the frame with no pulse; the next falling edge after release starts a fresh frame.

Verification (BAUD_CNT = 16 unless stated)
REQ-030 Stimulus: send 0xA5 with a good stop bit. Required: rx_data = 0xA5, one rx_rdy pulse, frm_err stays 0, pwr_up stays 0.
REQ-031 Stimulus: send 'G'. Required: pwr_up rises the cycle after rx_rdy. Then send 'S' with rider_off = 0. Required: pwr_up stays 1 (PWR2). Then raise rider_off. Required: pwr_up = 0 the next cycle.
REQ-032 Stimulus: send 'G', then 'S' with rider_off = 1. Required: pwr_up falls the cycle after the 'S' rx_rdy.
REQ-033 Stimulus: send 0x47 with the stop bit forced low, holding RX low for 40 cycles. Required: one frm_err pulse, no rx_rdy, pwr_up stays 0, no new frame until RX returns high.
REQ-034 Stimulus: RX low glitch of 3 cycles. Required: false start, no pulses. Stimulus: rst mid-DATA. Required: all outputs are at reset values and the next frame, 0x3C, is received correctly.
REQ-035 Stimulus: BAUD_CNT = 2604, send back-to-back 'G', 'S' at 19200 baud with rider_off = 1. Required: two rx_rdy pulses, and pwr_up ends at 0.

Source files
------------

// File: rtl/auth_rx.sv
// auth_rx: 8N1 UART receiver feeding a 'G'/'S' command FSM that drives the
// balance-controller power enable. Shutdown requested while a rider is still
// on is deferred until the load cells report the rider has stepped off.
module auth_rx #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_CNT);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_CNT / 2);
  localparam logic [7:0]  CMD_GO    = 8'h47;
  localparam logic [7:0]  CMD_STOP  = 8'h53;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_e;
  typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_e;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q;
  logic [7:0]  shift_q, rx_data_q;
  logic        rx_rdy_q, frm_err_q;
  auth_state_e auth_q;
  logic        pwr_q;
  logic        fall_edge, baud_tick;

  // Saturating decrement: the baud counter never wraps below zero.
  function automatic logic [11:0] sat_dec(input logic [11:0] v);
    return (v == 12'd0) ? 12'd0 : v - 12'd1;
  endfunction

  // The counter reaches zero on the cycle it steps from 1 (or sits at 0);
  // sampling there and reloading gives a sample period of exactly BAUD_CNT.
  assign baud_d    = sat_dec(baud_q);
  assign baud_tick = (baud_q <= 12'd1);
  assign fall_edge = rx_prev_q & ~rx_sync_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver FSM: start validation, LSB-first data capture, stop-bit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      baud_q     <= 12'd0;
      bit_q      <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (fall_edge) begin
            baud_q     <= BAUD_HALF;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (baud_tick) begin
            baud_q     <= BAUD_FULL;
            bit_q      <= 4'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_d;
          end
        end
        RX_DATA: begin
          if (baud_tick) begin
            baud_q  <= BAUD_FULL;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 4'd1;
            if (bit_q == 4'd7) rx_state_q <= RX_STOP;
          end else begin
            baud_q <= baud_d;
          end
        end
        RX_STOP: begin
          if (baud_tick) begin
            baud_q <= BAUD_FULL;
            if (rx_sync_q) begin
              rx_data_q  <= shift_q;
              rx_rdy_q   <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              frm_err_q  <= 1'b1;
              rx_state_q <= RX_WAIT_HI;
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        RX_WAIT_HI: begin
          // A held-low line (break) must go high before a new start is armed.
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Auth FSM: 'G' powers up, 'S' powers down once the rider is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_q <= AUTH_OFF;
      pwr_q  <= 1'b0;
    end else begin
      case (auth_q)
        AUTH_OFF: begin
          if (rx_rdy_q && rx_data_q == CMD_GO) begin
            auth_q <= AUTH_PWR1;
            pwr_q  <= 1'b1;
          end
        end
        AUTH_PWR1: begin
          if (rx_rdy_q && rx_data_q == CMD_STOP) begin
            if (rider_off) begin
              auth_q <= AUTH_OFF;
              pwr_q  <= 1'b0;
            end else begin
              auth_q <= AUTH_PWR2;
              pwr_q  <= 1'b1;
            end
          end
        end
        AUTH_PWR2: begin
          // A fresh 'G' cancels the pending stop even if the rider leaves now.
          if (rx_rdy_q && rx_data_q == CMD_GO) begin
            auth_q <= AUTH_PWR1;
            pwr_q  <= 1'b1;
          end else if (rider_off) begin
            auth_q <= AUTH_OFF;
            pwr_q  <= 1'b0;
          end
        end
        default: begin
          auth_q <= AUTH_OFF;
          pwr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign frm_err = frm_err_q;
  assign pwr_up  = pwr_q;

endmodule

// File: tb/tb_auth_rx.sv
// tb_auth_rx: scoreboard bench for auth_rx. Stimulus pushes expected events
// (byte/framing error plus power state before/after) into a queue; a monitor
// pops them whenever the DUT pulses rx_rdy or frm_err.
`timescale 1ns/1ps
module tb_auth_rx;

  localparam int BAUD      = 16;
  localparam int BAUD_SLOW = 2604;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fast instance (BAUD_CNT = 16)
  logic       rst, RX, rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy, frm_err, pwr_up;

  // Slow instance (BAUD_CNT = 2604)
  logic       rst_s, RX_s, rider_off_s;
  logic [7:0] rx_data_s;
  logic       rx_rdy_s, frm_err_s, pwr_up_s;

  auth_rx #(.BAUD_CNT(BAUD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err), .pwr_up(pwr_up)
  );

  auth_rx #(.BAUD_CNT(BAUD_SLOW)) dut_slow (
    .clk(clk), .rst(rst_s), .RX(RX_s), .rider_off(rider_off_s),
    .rx_data(rx_data_s), .rx_rdy(rx_rdy_s), .frm_err(frm_err_s), .pwr_up(pwr_up_s)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic       pwr_before;
    logic       pwr_after;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_pushed = 0;
  int         n_pulses = 0;
  logic [7:0] last_good = 8'h00;

  // Reference model of the command rules: powered, and "stop pending".
  bit model_on  = 1'b0;
  bit model_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic roff);
    if (!model_on) begin
      if (b == 8'h47) model_on = 1'b1;
    end else if (!model_req) begin
      if (b == 8'h53) begin
        if (roff) model_on = 1'b0;
        else      model_req = 1'b1;
      end
    end else if (b == 8'h47) begin
      model_req = 1'b0;
    end
  endtask

  task automatic hold_rx(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int stop_len);
    exp_t e;
    e.err        = !stop_ok;
    e.data       = b;
    e.pwr_before = model_on;
    if (stop_ok) model_byte(b, rider_off);
    e.pwr_after  = model_on;
    exp_q.push_back(e);
    n_pushed++;
    hold_rx(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold_rx(b[i], BAUD);
    hold_rx(stop_ok, stop_len);
    RX = 1'b1;
  endtask

  task automatic set_rider(input logic v);
    rider_off = v;
    if (v && model_req) begin
      model_on  = 1'b0;
      model_req = 1'b0;
    end
    @(negedge clk);
    check("pwr_after_rider", pwr_up, model_on);
  endtask

  // Scoreboard monitor for the fast instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_rdy || frm_err) begin
        n_pulses++;
        check("rdy_err_exclusive", rx_rdy & frm_err, 1'b0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse: rx_rdy=%0b frm_err=%0b rx_data=%0h, expected no pulse", rx_rdy, frm_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          check("frm_err", frm_err, e.err);
          check("rx_rdy", rx_rdy, !e.err);
          if (!e.err) begin
            check("rx_data", rx_data, e.data);
            last_good = e.data;
          end else begin
            check("rx_data_kept", rx_data, last_good);
          end
          check("pwr_before", pwr_up, e.pwr_before);
          @(negedge clk);
          check("pwr_after", pwr_up, e.pwr_after);
          check("no_consecutive_pulse", rx_rdy | frm_err, 1'b0);
        end
      end
    end
  end

  // Slow-instance monitor: records received bytes and the power state after each.
  int         slow_cnt = 0;
  int         slow_err = 0;
  logic [7:0] slow_data[4];
  logic       slow_pwr[4];
  initial begin
    forever begin
      @(negedge clk);
      if (frm_err_s) slow_err++;
      if (rx_rdy_s) begin
        if (slow_cnt < 4) slow_data[slow_cnt] = rx_data_s;
        @(negedge clk);
        if (slow_cnt < 4) slow_pwr[slow_cnt] = pwr_up_s;
        slow_cnt++;
      end
    end
  end

  task automatic main_seq();
    logic [7:0] b;
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_rdy", rx_rdy, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_pwr_up", pwr_up, 1'b0);
    rst = 1'b0;
    hold_rx(1'b1, 5);

    // Plain byte: no power change.
    send_byte(8'hA5, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);

    // 'G', then 'S' with rider on (stop pending), then rider steps off.
    send_byte(8'h47, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);
    send_byte(8'h53, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);
    check("pwr2_holds", pwr_up, 1'b1);
    set_rider(1'b1);

    // 'G', then 'S' with rider already off: immediate shutdown.
    send_byte(8'h47, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);
    send_byte(8'h53, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);

    // 'G' with a low stop bit and a 40-cycle break: error only, no power.
    send_byte(8'h47, 1'b0, 40);
    hold_rx(1'b1, 2 * BAUD);
    check("pwr_after_frm_err", pwr_up, 1'b0);

    // 3-cycle glitch: false start, monitor flags any pulse.
    hold_rx(1'b0, 3);
    hold_rx(1'b1, 3 * BAUD);

    // Reset in the middle of the data bits while powered.
    set_rider(1'b0);
    send_byte(8'h47, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);
    hold_rx(1'b0, BAUD);
    hold_rx(1'b0, 4 * BAUD);
    rst = 1'b1; RX = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_rdy", rx_rdy, 1'b0);
    check("midrst_frm_err", frm_err, 1'b0);
    check("midrst_pwr_up", pwr_up, 1'b0);
    rst = 1'b0;
    model_on = 1'b0; model_req = 1'b0; last_good = 8'h00;
    hold_rx(1'b1, 3 * BAUD);
    send_byte(8'h3C, 1'b1, BAUD);
    hold_rx(1'b1, 2 * BAUD);

    // Randomized command/data mix with occasional rider changes and bad stops.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) set_rider(1'($urandom_range(0, 1)));
      case ($urandom_range(0, 2))
        0:       b = 8'h47;
        1:       b = 8'h53;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        send_byte(b, 1'b0, BAUD + int'($urandom_range(0, 20)));
        hold_rx(1'b1, 2 + int'($urandom_range(0, 3)));
      end else begin
        send_byte(b, 1'b1, BAUD);
        hold_rx(1'b1, int'($urandom_range(0, 3)));
      end
    end
    hold_rx(1'b1, 3 * BAUD);
    check("queue_drained", exp_q.size(), 0);
    check("pulse_count", n_pulses, n_pushed);
  endtask

  task automatic slow_bits(input logic [7:0] b);
    RX_s = 1'b0;
    repeat (BAUD_SLOW) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_s = b[i];
      repeat (BAUD_SLOW) @(negedge clk);
    end
    RX_s = 1'b1;
    repeat (BAUD_SLOW) @(negedge clk);
  endtask

  task automatic slow_seq();
    rst_s = 1'b1; RX_s = 1'b1; rider_off_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    repeat (10) @(negedge clk);
    slow_bits(8'h47);
    slow_bits(8'h53);
    repeat (3000) @(negedge clk);
    check("slow_rdy_count", slow_cnt, 2);
    check("slow_frm_err_count", slow_err, 0);
    if (slow_cnt >= 2) begin
      check("slow_byte0", slow_data[0], 8'h47);
      check("slow_pwr0", slow_pwr[0], 1'b1);
      check("slow_byte1", slow_data[1], 8'h53);
      check("slow_pwr1", slow_pwr[1], 1'b0);
    end
    check("slow_pwr_final", pwr_up_s, 1'b0);
  endtask

  initial begin
    fork
      main_seq();
      slow_seq();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 900000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
